// File: rtl/microwave_controller.sv
// ---------------------------------------------------------------------------
// microwave_controller
//
// Purpose:
//   Front-panel sequencer for an M:SS countdown timer built from three BCD
//   digit counters. It collects keypad digits into an entry register, loads
//   that entry into the timer, and gates the timer's decrement with a
//   1-second tick taken from a clock prescaler. It also drives the magnetron
//   and the beeper. Door, start and stop events are handled by a 5-state FSM.
//
// Parameters:
//   TICK_DIV     clk cycles per 1-second tick
//   BEEP_CYCLES  cycles the beeper stays on at the end of cooking
//
// Ports:
//   clk            in   system clock, rising edge
//   clear          in   synchronous active-high reset
//   key_valid      in   one-cycle strobe qualifying key_digit
//   key_digit      in   BCD keypad digit (values above 9 are ignored)
//   start          in   start/resume request level
//   stop           in   pause/cancel request level
//   door_closed    in   1 = door shut
//   tc_min         in   timer minutes digit is zero
//   tc_sec_tens    in   timer seconds-tens digit is zero
//   tc_sec_ones    in   timer seconds-ones digit is zero
//   timer_load_n   out  active-low load strobe to the timer
//   timer_clear_n  out  active-low clear to the timer
//   timer_enable   out  one-cycle decrement strobe to the timer
//   min_set        out  entry minutes digit
//   sec_tens_set   out  entry seconds-tens digit
//   sec_ones_set   out  entry seconds-ones digit
//   magnetron_on   out  heating element enable
//   beep           out  end-of-cook beeper
//   err            out  one-cycle pulse when start is rejected (tens > 5)
//   state          out  IDLE=0 LOAD=1 COOK=2 PAUSE=3 DONE=4
// ---------------------------------------------------------------------------
module microwave_controller #(
  parameter int TICK_DIV    = 100,
  parameter int BEEP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  input  logic       tc_min,
  input  logic       tc_sec_tens,
  input  logic       tc_sec_ones,
  output logic       timer_load_n,
  output logic       timer_clear_n,
  output logic       timer_enable,
  output logic [3:0] min_set,
  output logic [3:0] sec_tens_set,
  output logic [3:0] sec_ones_set,
  output logic       magnetron_on,
  output logic       beep,
  output logic       err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_CYCLES - 1);

  state_t        cur_state;
  state_t        next_state;
  logic [PW-1:0] prescaler;
  logic [PW-1:0] prescaler_d;
  logic [BW-1:0] beep_cnt;
  logic [BW-1:0] beep_cnt_d;
  logic [3:0]    min_d;
  logic [3:0]    sec_tens_d;
  logic [3:0]    sec_ones_d;
  logic          load_n_d;
  logic          clear_n_d;
  logic          enable_d;
  logic          magnetron_d;
  logic          beep_d;
  logic          err_d;

  logic timer_zero;
  logic entry_zero;
  logic tens_bad;
  logic digit_ok;
  logic start_ok;

  assign timer_zero = tc_min & tc_sec_tens & tc_sec_ones;
  assign entry_zero = (min_set == 4'd0) && (sec_tens_set == 4'd0) && (sec_ones_set == 4'd0);
  assign tens_bad   = (sec_tens_set > 4'd5);
  assign digit_ok   = key_valid && (key_digit <= 4'd9);
  assign start_ok   = start && door_closed && !entry_zero;
  assign state      = cur_state;

  // State register.
  always_ff @(posedge clk) begin
    if (clear) begin
      cur_state <= IDLE;
    end else begin
      cur_state <= next_state;
    end
  end

  // Next-state logic. Within each state stop outranks the door, which
  // outranks start. A timer reading of zero only ends cooking when no
  // decrement is in flight, so 0:00 is never decremented.
  always_comb begin
    next_state = cur_state;
    case (cur_state)
      IDLE: begin
        if (!stop && start_ok && !tens_bad) next_state = LOAD;
      end
      LOAD: next_state = COOK;
      COOK: begin
        if (stop || !door_closed)              next_state = PAUSE;
        else if (timer_zero && !timer_enable)  next_state = DONE;
      end
      PAUSE: begin
        if (stop)                      next_state = IDLE;
        else if (door_closed && start) next_state = COOK;
      end
      DONE: begin
        if (stop || !door_closed || (beep_cnt == BEEP_LAST)) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output logic: computes the value every registered output takes on the
  // next edge. Magnetron and beep follow the state being entered so they
  // switch on the same edge as the state change. If cooking is interrupted
  // on the very cycle the enable fires, that second is already consumed, so
  // the prescaler wraps instead of holding; otherwise resuming would fire a
  // second enable immediately.
  always_comb begin
    min_d       = min_set;
    sec_tens_d  = sec_tens_set;
    sec_ones_d  = sec_ones_set;
    load_n_d    = 1'b1;
    clear_n_d   = 1'b1;
    err_d       = 1'b0;
    prescaler_d = prescaler;
    beep_cnt_d  = '0;
    magnetron_d = (next_state == COOK);
    beep_d      = (next_state == DONE);
    case (cur_state)
      IDLE: begin
        if (stop) begin
          min_d      = 4'd0;
          sec_tens_d = 4'd0;
          sec_ones_d = 4'd0;
          clear_n_d  = 1'b0;
        end else if (start_ok) begin
          if (tens_bad) err_d    = 1'b1;
          else          load_n_d = 1'b0;
        end else if (digit_ok) begin
          min_d      = sec_tens_set;
          sec_tens_d = sec_ones_set;
          sec_ones_d = key_digit;
        end
      end
      LOAD: prescaler_d = '0;
      COOK: begin
        if (next_state == COOK || prescaler == PRE_LAST) begin
          prescaler_d = (prescaler == PRE_LAST) ? '0 : prescaler + PW'(1);
        end
      end
      PAUSE: begin
        if (stop) begin
          min_d      = 4'd0;
          sec_tens_d = 4'd0;
          sec_ones_d = 4'd0;
          clear_n_d  = 1'b0;
        end
      end
      DONE: begin
        beep_cnt_d = beep_cnt + BW'(1);
        if (next_state == IDLE) begin
          min_d      = 4'd0;
          sec_tens_d = 4'd0;
          sec_ones_d = 4'd0;
        end
      end
      default: ;
    endcase
    enable_d = (next_state == COOK) && (prescaler_d == PRE_LAST);
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (clear) begin
      min_set       <= 4'd0;
      sec_tens_set  <= 4'd0;
      sec_ones_set  <= 4'd0;
      timer_load_n  <= 1'b1;
      timer_clear_n <= 1'b0;
      timer_enable  <= 1'b0;
      magnetron_on  <= 1'b0;
      beep          <= 1'b0;
      err           <= 1'b0;
      prescaler     <= '0;
      beep_cnt      <= '0;
    end else begin
      min_set       <= min_d;
      sec_tens_set  <= sec_tens_d;
      sec_ones_set  <= sec_ones_d;
      timer_load_n  <= load_n_d;
      timer_clear_n <= clear_n_d;
      timer_enable  <= enable_d;
      magnetron_on  <= magnetron_d;
      beep          <= beep_d;
      err           <= err_d;
      prescaler     <= prescaler_d;
      beep_cnt      <= beep_cnt_d;
    end
  end

endmodule

// File: tb/tb_microwave_controller.sv
// ---------------------------------------------------------------------------
// tb_microwave_controller
//
// Directed bench for microwave_controller. A small BCD countdown timer model
// stands in for the real timer and feeds the tc_* flags back to the DUT.
// Expected values are queued before each step and popped as outputs appear.
// ---------------------------------------------------------------------------
module tb_microwave_controller;

  logic       clk = 1'b0;
  logic       clear;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       start;
  logic       stop;
  logic       door_closed;
  logic       tc_min;
  logic       tc_sec_tens;
  logic       tc_sec_ones;
  logic       timer_load_n;
  logic       timer_clear_n;
  logic       timer_enable;
  logic [3:0] min_set;
  logic [3:0] sec_tens_set;
  logic [3:0] sec_ones_set;
  logic       magnetron_on;
  logic       beep;
  logic       err;
  logic [2:0] state;

  logic [3:0]  t_min  = 4'd0;
  logic [3:0]  t_tens = 4'd0;
  logic [3:0]  t_ones = 4'd0;
  logic [11:0] entry_word;
  logic [11:0] timer_word;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   c;
  int   pulses;
  int   last_c;
  int   bad_gap;
  int   n;

  always #5 clk = ~clk;

  microwave_controller #(.TICK_DIV(100), .BEEP_CYCLES(4)) dut (
    .clk           (clk),
    .clear         (clear),
    .key_valid     (key_valid),
    .key_digit     (key_digit),
    .start         (start),
    .stop          (stop),
    .door_closed   (door_closed),
    .tc_min        (tc_min),
    .tc_sec_tens   (tc_sec_tens),
    .tc_sec_ones   (tc_sec_ones),
    .timer_load_n  (timer_load_n),
    .timer_clear_n (timer_clear_n),
    .timer_enable  (timer_enable),
    .min_set       (min_set),
    .sec_tens_set  (sec_tens_set),
    .sec_ones_set  (sec_ones_set),
    .magnetron_on  (magnetron_on),
    .beep          (beep),
    .err           (err),
    .state         (state)
  );

  assign entry_word  = {min_set, sec_tens_set, sec_ones_set};
  assign timer_word  = {t_min, t_tens, t_ones};
  assign tc_min      = (t_min == 4'd0);
  assign tc_sec_tens = (t_tens == 4'd0);
  assign tc_sec_ones = (t_ones == 4'd0);

  // Countdown timer model: clear beats load beats decrement; wraps at 0:00
  // so an illegal decrement shows up as 9:59.
  always @(posedge clk) begin
    if (!timer_clear_n) begin
      t_min <= 4'd0; t_tens <= 4'd0; t_ones <= 4'd0;
    end else if (!timer_load_n) begin
      t_min <= min_set; t_tens <= sec_tens_set; t_ones <= sec_ones_set;
    end else if (timer_enable) begin
      if (t_ones != 4'd0) begin
        t_ones <= t_ones - 4'd1;
      end else begin
        t_ones <= 4'd9;
        if (t_tens != 4'd0) begin
          t_tens <= t_tens - 4'd1;
        end else begin
          t_tens <= 4'd5;
          t_min  <= (t_min != 4'd0) ? t_min - 4'd1 : 4'd9;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic kv, input logic [3:0] kd, input logic st,
                               input logic sp, input logic dc, input logic clr);
    key_valid   = kv;
    key_digit   = kd;
    start       = st;
    stop        = sp;
    door_closed = dc;
    clear       = clr;
  endtask

  task automatic push_expect(input string tag, input logic [31:0] value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] observed);
    exp_t e;
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $error("[TB] FAIL scoreboard_empty: observed %0h, expected nothing queued", observed);
    end else begin
      e = sb.pop_front();
      assert (observed === e.value) else begin
        mismatched++;
        $error("[TB] FAIL %s: observed %0h expected %0h", e.tag, observed, e.value);
      end
    end
  endtask

  task automatic press_key(input logic [3:0] d);
    applyStimulus(1'b1, d, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic idle_inputs();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    tick();
    push_expect("reset_state", 0);
    push_expect("reset_load_n", 1);
    push_expect("reset_clear_n", 0);
    push_expect("reset_enable", 0);
    push_expect("reset_magnetron", 0);
    push_expect("reset_beep", 0);
    push_expect("reset_err", 0);
    push_expect("reset_entry", 0);
    checkOutput(32'(state));
    checkOutput(32'(timer_load_n));
    checkOutput(32'(timer_clear_n));
    checkOutput(32'(timer_enable));
    checkOutput(32'(magnetron_on));
    checkOutput(32'(beep));
    checkOutput(32'(err));
    checkOutput(32'(entry_word));
    idle_inputs();
    push_expect("clear_n_release", 1);
    tick();
    checkOutput(32'(timer_clear_n));

    // Entry 0:75 is rejected with an err pulse
    press_key(4'd0);
    press_key(4'd7);
    press_key(4'd5);
    push_expect("entry_075", 32'h075);
    checkOutput(32'(entry_word));
    press_key(4'd12);
    push_expect("key_gt9_ignored", 32'h075);
    checkOutput(32'(entry_word));
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    push_expect("err_pulse", 1);
    push_expect("err_state_idle", 0);
    push_expect("err_load_n_high", 1);
    tick();
    checkOutput(32'(err));
    checkOutput(32'(state));
    checkOutput(32'(timer_load_n));
    idle_inputs();
    push_expect("err_one_cycle", 0);
    tick();
    checkOutput(32'(err));
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    push_expect("idle_stop_clear_n", 0);
    push_expect("idle_stop_entry", 0);
    tick();
    checkOutput(32'(timer_clear_n));
    checkOutput(32'(entry_word));
    idle_inputs();
    push_expect("idle_stop_clear_n_release", 1);
    tick();
    checkOutput(32'(timer_clear_n));

    // Start ignored with door open, and with entry 0:00
    press_key(4'd2);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    push_expect("door_open_start_state", 0);
    push_expect("door_open_start_load_n", 1);
    tick();
    checkOutput(32'(state));
    checkOutput(32'(timer_load_n));
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    idle_inputs();
    tick();
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    push_expect("zero_entry_start_state", 0);
    push_expect("zero_entry_start_load_n", 1);
    tick();
    checkOutput(32'(state));
    checkOutput(32'(timer_load_n));
    idle_inputs();
    tick();

    // Full 1:30 cook
    press_key(4'd1);
    press_key(4'd3);
    press_key(4'd0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    push_expect("load_state", 1);
    push_expect("load_n_low", 0);
    push_expect("load_entry", 32'h130);
    tick();
    checkOutput(32'(state));
    checkOutput(32'(timer_load_n));
    checkOutput(32'(entry_word));
    idle_inputs();
    push_expect("cook_state", 2);
    push_expect("cook_magnetron", 1);
    push_expect("cook_load_n_high", 1);
    tick();
    checkOutput(32'(state));
    checkOutput(32'(magnetron_on));
    checkOutput(32'(timer_load_n));
    pulses  = 0;
    last_c  = 0;
    bad_gap = 0;
    for (c = 1; c <= 12000; c++) begin
      if (state == 3'd4) break;
      if (timer_enable) begin
        if (c - last_c != 100) bad_gap++;
        last_c = c;
        pulses++;
      end
      tick();
    end
    push_expect("done_reached", 4);
    push_expect("enable_pulses", 90);
    push_expect("enable_gap_errors", 0);
    push_expect("no_decrement_at_zero", 0);
    push_expect("done_beep", 1);
    push_expect("done_magnetron_off", 0);
    checkOutput(32'(state));
    checkOutput(32'(pulses));
    checkOutput(32'(bad_gap));
    checkOutput(32'(timer_word));
    checkOutput(32'(beep));
    checkOutput(32'(magnetron_on));
    n = 0;
    for (int k = 0; k < 20 && beep; k++) begin
      n++;
      tick();
    end
    push_expect("beep_cycles", 4);
    push_expect("after_done_state", 0);
    push_expect("after_done_entry", 0);
    checkOutput(32'(n));
    checkOutput(32'(state));
    checkOutput(32'(entry_word));

    // Door opened at prescaler 40, then resume
    press_key(4'd2);
    press_key(4'd0);
    press_key(4'd0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    idle_inputs();
    tick();
    repeat (40) tick();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_expect("pause_state", 3);
    push_expect("pause_magnetron", 0);
    tick();
    checkOutput(32'(state));
    checkOutput(32'(magnetron_on));
    idle_inputs();
    repeat (5) tick();
    push_expect("pause_hold_state", 3);
    push_expect("pause_enable", 0);
    checkOutput(32'(state));
    checkOutput(32'(timer_enable));
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    push_expect("resume_state", 2);
    push_expect("resume_magnetron", 1);
    tick();
    checkOutput(32'(state));
    checkOutput(32'(magnetron_on));
    idle_inputs();
    for (c = 1; c <= 200; c++) begin
      if (timer_enable) break;
      tick();
    end
    push_expect("resume_enable_delay", 60);
    checkOutput(32'(c));
    tick();
    push_expect("timer_after_first_second", 32'h159);
    checkOutput(32'(timer_word));

    // Pause then stop cancels
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_expect("pause2_state", 3);
    tick();
    checkOutput(32'(state));
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    push_expect("stop_state_idle", 0);
    push_expect("stop_clear_n_low", 0);
    push_expect("stop_entry_zero", 0);
    tick();
    checkOutput(32'(state));
    checkOutput(32'(timer_clear_n));
    checkOutput(32'(entry_word));
    idle_inputs();
    push_expect("stop_clear_n_one_cycle", 1);
    tick();
    checkOutput(32'(timer_clear_n));

    // clear mid-cook
    press_key(4'd0);
    press_key(4'd0);
    press_key(4'd9);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    idle_inputs();
    tick();
    repeat (10) tick();
    push_expect("precheck_cook", 2);
    checkOutput(32'(state));
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    push_expect("clr_state", 0);
    push_expect("clr_magnetron", 0);
    push_expect("clr_clear_n", 0);
    push_expect("clr_load_n", 1);
    push_expect("clr_enable", 0);
    push_expect("clr_entry", 0);
    push_expect("clr_beep", 0);
    push_expect("clr_err", 0);
    tick();
    checkOutput(32'(state));
    checkOutput(32'(magnetron_on));
    checkOutput(32'(timer_clear_n));
    checkOutput(32'(timer_load_n));
    checkOutput(32'(timer_enable));
    checkOutput(32'(entry_word));
    checkOutput(32'(beep));
    checkOutput(32'(err));
    idle_inputs();
    push_expect("clr_release_clear_n", 1);
    tick();
    checkOutput(32'(timer_clear_n));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
